cache_axi_rd_bridge: RTL

CACHE_AXI_RD_BRIDGE -- requirements
Module: cache_axi_rd_bridge

---
 rtl/cache_axi_rd_bridge.sv | 137 +++++++++++++
 1 files changed

// File: rtl/cache_axi_rd_bridge.sv
// Cache line-refill bridge: turns a single cache line-read request into one
// AXI4 INCR burst of four 32-bit beats and returns the assembled 128-bit line.
// One request in flight at a time. Optional sticky protocol/response error
// detection is compiled in with `define AXI_RD_ERR_CHECK_EN.
module cache_axi_rd_bridge #(
  parameter int unsigned          AXI_ID_W = 4,
  parameter logic [AXI_ID_W-1:0]  ARID_VAL = '0
) (
  input  logic                clk,
  input  logic                rst,
  // Cache side
  input  logic                rd_req,
  input  logic [31:0]         rd_addr,
  output logic                rd_rdy,
  output logic                ret_valid,
  output logic                ret_last,
  output logic [127:0]        ret_data,
  // AXI4 read address channel
  output logic [AXI_ID_W-1:0] arid,
  output logic [31:0]         araddr,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic                arvalid,
  input  logic                arready,
  // AXI4 read data channel
  input  logic [AXI_ID_W-1:0] rid,
  input  logic [31:0]         rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready,
  // Status
  output logic                rd_err
);

  typedef enum logic [1:0] {StIdle, StAr, StR, StRet} state_e;

  state_e       r_state;
  logic [1:0]   r_beat;
  logic [31:0]  r_addr;
  logic [127:0] r_data;
  logic         r_arvalid;
  logic         r_rready;
  logic         r_ret_valid;
  logic         r_ret_last;
  logic         w_beat_ok;
  logic         w_unused;

  // rid is not checked and the low address bits are dropped by line alignment
  assign w_unused  = ^{rid, rresp, rlast, rd_addr[3:0]};

  assign w_beat_ok = rvalid && r_rready;

  // Request acceptance is purely a function of being idle
  assign rd_rdy    = (r_state == StIdle);

  assign arid      = ARID_VAL;
  assign araddr    = r_addr;
  assign arlen     = 8'd3;
  assign arsize    = 3'd2;
  assign arburst   = 2'b01;
  assign arvalid   = r_arvalid;
  assign rready    = r_rready;
  assign ret_valid = r_ret_valid;
  assign ret_last  = r_ret_last;
  assign ret_data  = r_data;

  // Main FSM with registered handshake and return outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_beat      <= 2'd0;
      r_addr      <= 32'd0;
      r_data      <= 128'd0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_ret_valid <= 1'b0;
      r_ret_last  <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (rd_req) begin
            r_addr    <= {rd_addr[31:4], 4'b0000};
            r_arvalid <= 1'b1;
            r_state   <= StAr;
          end
        end
        StAr: begin
          if (arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_beat    <= 2'd0;
            r_state   <= StR;
          end
        end
        StR: begin
          if (w_beat_ok) begin
            r_data[32*r_beat +: 32] <= rdata;
            r_beat                  <= r_beat + 2'd1;
            // Beat count alone ends the burst; rlast is only checked for errors
            if (r_beat == 2'd3) begin
              r_rready    <= 1'b0;
              r_ret_valid <= 1'b1;
              r_ret_last  <= 1'b1;
              r_state     <= StRet;
            end
          end
        end
        StRet: begin
          r_ret_valid <= 1'b0;
          r_ret_last  <= 1'b0;
          r_state     <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

`ifdef AXI_RD_ERR_CHECK_EN
  logic r_err;

  // Sticky error on bad response or rlast on the wrong beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_beat_ok && ((rresp != 2'b00) || (rlast != (r_beat == 2'd3)))) begin
      r_err <= 1'b1;
    end
  end

  assign rd_err = r_err;
`else
  assign rd_err = 1'b0;
`endif

endmodule
